// File: rtl/booth_product_accumulator.sv
// Saturating accumulator for a stream of signed Booth products.
// Sums up to COUNT products per window (closed early by in_last), clamps
// to the signed ACC_WIDTH range with a sticky overflow flag, and holds the
// result until the downstream stage takes it.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The sender keeps valid and its data stable until that edge;
// ready may change freely and never depends on valid in the same cycle.
module booth_product_accumulator #(
  parameter int WIDTH     = 9,
  parameter int ACC_WIDTH = 24,
  parameter int COUNT     = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [2*WIDTH-1:0]      in_prod,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [ACC_WIDTH-1:0]    out_sum,
  output logic [$clog2(COUNT+1)-1:0]     out_count,
  output logic                           out_ovf,
  output logic                           dbg_state
);

  localparam int CW = $clog2(COUNT + 1);
  localparam logic [CW-1:0] COUNT_C = CW'(COUNT);
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t                       state;
  state_t                       state_next;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [ACC_WIDTH-1:0]  acc_next;
  logic signed [ACC_WIDTH:0]    sum_ext;
  logic [CW-1:0]                cnt;
  logic [CW-1:0]                cnt_inc;
  logic                         ovf;
  logic                         sat_hi;
  logic                         sat_lo;
  logic                         accept;
  logic                         close_win;
  logic                         release_res;

  assign accept      = in_valid && (state == ACCUM);
  assign cnt_inc     = cnt + CW'(1);
  assign close_win   = accept && (in_last || (cnt_inc == COUNT_C));
  assign release_res = (state == HOLD) && out_ready;

  // One guard bit is enough: ACC_WIDTH >= 2*WIDTH, so a single add of a
  // product to a clamped value can overshoot the range by at most one bit.
  always_comb begin
    sum_ext  = {acc[ACC_WIDTH-1], acc}
             + {{(ACC_WIDTH+1-2*WIDTH){in_prod[2*WIDTH-1]}}, in_prod};
    sat_hi   = !sum_ext[ACC_WIDTH] &&  sum_ext[ACC_WIDTH-1];
    sat_lo   =  sum_ext[ACC_WIDTH] && !sum_ext[ACC_WIDTH-1];
    acc_next = sum_ext[ACC_WIDTH-1:0];
    if (sat_hi) begin
      acc_next = ACC_MAX;
    end else if (sat_lo) begin
      acc_next = ACC_MIN;
    end
  end

  // Next-state: close a window into HOLD, release it on the output handshake.
  always_comb begin
    state_next = state;
    case (state)
      ACCUM:   if (close_win)   state_next = HOLD;
      HOLD:    if (release_res) state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ACCUM;
    end else begin
      state <= state_next;
    end
  end

  // Window datapath: accumulate accepted beats, clear on reset or release.
  always_ff @(posedge clk) begin
    if (!rst_n || release_res) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
      acc <= acc_next;
      cnt <= cnt_inc;
      ovf <= ovf || sat_hi || sat_lo;
    end
  end

  // Results are only meaningful in HOLD; they read as zero while accumulating.
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign out_sum   = out_valid ? acc : '0;
  assign out_count = out_valid ? cnt : '0;
  assign out_ovf   = out_valid && ovf;
  assign dbg_state = state;

endmodule
